// File: rtl/instr_encoder_if.sv
// Field-bundle input and instruction-memory write port of the instruction encoder.
// The loader (or a test harness) uses the master side. The encoder uses the slave side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic signed [31:0] imm;
  logic              last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        err_code;

  modport master (
    output start, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code
  );

  modport slave (
    input  start, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, last,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, err_code
  );
endinterface

// File: rtl/instr_encoder.sv
// RISC-V instruction encoder. It packs R/I/S/B/U/J field bundles into 32-bit words.
// Each accepted bundle is written one cycle later to an auto-incrementing word address.
// A bundle that fails a check is written as a NOP, so the word addresses stay aligned.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           rst,
  instr_encoder_if.slave bus
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [31:0]       NOP     = 32'h0000_0013;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_RANGE = 3'd1;
  localparam logic [2:0] ERR_MIS   = 3'd2;
  localparam logic [2:0] ERR_FMT   = 3'd3;
  localparam logic [2:0] ERR_ADDR  = 3'd4;

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_cnt;
  logic              err_q;
  logic [2:0]        code_q;

  // Packs the fields into the instruction word for the given format.
  function automatic logic [31:0] encode(
    input logic [2:0]         f,
    input logic [6:0]         op,
    input logic [4:0]         rd_f,
    input logic [4:0]         rs1_f,
    input logic [4:0]         rs2_f,
    input logic [2:0]         f3,
    input logic [6:0]         f7,
    input logic signed [31:0] v
  );
    case (f)
      FMT_R:   encode = {f7, rs2_f, rs1_f, f3, rd_f, op};
      FMT_I:   encode = {v[11:0], rs1_f, f3, rd_f, op};
      FMT_S:   encode = {v[11:5], rs2_f, rs1_f, f3, v[4:0], op};
      FMT_B:   encode = {v[12], v[10:5], rs2_f, rs1_f, f3, v[4:1], v[11], op};
      FMT_U:   encode = {v[31:12], rd_f, op};
      FMT_J:   encode = {v[20], v[10:1], v[11], v[19:12], rd_f, op};
      default: encode = NOP;
    endcase
  endfunction

  // Reports the highest-priority problem of a bundle: illegal fmt, then misaligned, then range.
  function automatic logic [2:0] check_beat(
    input logic [2:0]         f,
    input logic signed [31:0] v
  );
    check_beat = ERR_NONE;
    case (f)
      FMT_R: check_beat = ERR_NONE;
      FMT_I, FMT_S: begin
        if (v < -32'sd2048 || v > 32'sd2047) check_beat = ERR_RANGE;
      end
      FMT_B: begin
        if (v[0])                                check_beat = ERR_MIS;
        else if (v < -32'sd4096 || v > 32'sd4094) check_beat = ERR_RANGE;
      end
      FMT_U: begin
        if (v[11:0] != 12'd0) check_beat = ERR_MIS;
      end
      FMT_J: begin
        if (v[0])                                      check_beat = ERR_MIS;
        else if (v < -32'sd1048576 || v > 32'sd1048574) check_beat = ERR_RANGE;
      end
      default: check_beat = ERR_FMT;
    endcase
  endfunction

  // ---- stage p0: accept, encode and check the incoming bundle ----
  logic        acc_p0;
  logic        ovf_p0;
  logic        start_p0;
  logic [2:0]  code_p0;
  logic [31:0] word_p0;

  assign bus.in_ready = (state_q == LOAD);
  assign acc_p0       = bus.in_valid & bus.in_ready;
  assign start_p0     = bus.start & (state_q == IDLE);
  assign ovf_p0       = acc_p0 & ~bus.last & (addr_cnt == {ADDR_W{1'b1}});
  assign code_p0      = check_beat(bus.fmt, bus.imm);
  assign word_p0      = (code_p0 != ERR_NONE) ? NOP
                      : encode(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                               bus.funct3, bus.funct7, bus.imm);

  // Next state: a session runs until its last bundle or until the address space is exhausted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_p0) state_d = LOAD;
      LOAD: if (acc_p0 && (bus.last || ovf_p0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Write-address counter: reloaded at session start, advanced once per accepted bundle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           addr_cnt <= BASE;
    else if (start_p0) addr_cnt <= BASE;
    else if (acc_p0)   addr_cnt <= addr_cnt + 1'b1;
  end

  // Sticky error flag. The code keeps the first error of the session until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else if (start_p0) begin
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else if (acc_p0 && (code_p0 != ERR_NONE || ovf_p0)) begin
      err_q <= 1'b1;
      if (code_q == ERR_NONE) code_q <= (code_p0 != ERR_NONE) ? code_p0 : ERR_ADDR;
    end
  end

  // ---- stage p1: registered memory write ----
  logic              vld_p1;
  logic              done_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;

  // Write port register. Address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      addr_p1  <= BASE;
      wdata_p1 <= 32'd0;
    end else begin
      vld_p1  <= acc_p0;
      done_p1 <= acc_p0 & bus.last;
      if (acc_p0) begin
        addr_p1  <= addr_cnt;
        wdata_p1 <= word_p0;
      end
    end
  end

  assign bus.mem_we    = vld_p1;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;
  assign bus.done      = done_p1;
  assign bus.busy      = (state_q != IDLE) | vld_p1;
  assign bus.err       = err_q;
  assign bus.err_code  = code_q;

endmodule
